// File: rtl/hazard_control_unit_pkg.sv
// Shared pipeline types for the hazard controller: forward-select encodings,
// controller FSM states and register-index width.
package pipeline_pkg;

  localparam int REG_W   = 5;
  localparam int NUM_OPS = 2;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } hcu_state_e;

  // Register x0 is hardwired zero and never a real dependency.
  function automatic logic reg_hit(input logic [REG_W-1:0] dst,
                                   input logic [REG_W-1:0] src);
    return (dst != '0) && (dst == src);
  endfunction

endpackage

// File: rtl/hazard_control_unit_if.sv
// Stage-register fields in, stage enables / flushes / forward selects out.
// master = pipeline datapath side, slave = hazard controller side.
interface hazard_control_unit_if #(
  parameter int CNT_W = 32
) ();

  logic [pipeline_pkg::REG_W-1:0] id_rs1, id_rs2;
  logic                           id_uses_rs1, id_uses_rs2;
  logic [pipeline_pkg::REG_W-1:0] ex_rs1, ex_rs2, ex_rd;
  logic                           ex_mem_read;
  logic                           ex_branch_taken;
  logic [pipeline_pkg::REG_W-1:0] mem_rd;
  logic                           mem_reg_write;
  logic                           mem_access;
  logic                           dmem_ready;
  logic [pipeline_pkg::REG_W-1:0] wb_rd;
  logic                           wb_reg_write;

  logic                           pc_write, if_id_write;
  logic                           id_ex_write, ex_mem_write, mem_wb_write;
  logic                           if_id_flush, id_ex_flush;
  pipeline_pkg::fwd_sel_e         forward_a, forward_b;
  logic                           mem_timeout;
  logic [CNT_W-1:0]               stall_count, flush_count;

  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
    output ex_rs1, ex_rs2, ex_rd, ex_mem_read, ex_branch_taken,
    output mem_rd, mem_reg_write, mem_access, dmem_ready,
    output wb_rd, wb_reg_write,
    input  pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
    input  if_id_flush, id_ex_flush, forward_a, forward_b,
    input  mem_timeout, stall_count, flush_count
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
    input  ex_rs1, ex_rs2, ex_rd, ex_mem_read, ex_branch_taken,
    input  mem_rd, mem_reg_write, mem_access, dmem_ready,
    input  wb_rd, wb_reg_write,
    output pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
    output if_id_flush, id_ex_flush, forward_a, forward_b,
    output mem_timeout, stall_count, flush_count
  );

endinterface

// File: rtl/hazard_control_unit_fwd.sv
// Per-operand EX forwarding select; the younger EX/MEM result shadows MEM/WB.
module forwarding_unit
  import pipeline_pkg::*;
(
  input  logic [REG_W-1:0] i_ex_rs,
  input  logic [REG_W-1:0] i_mem_rd,
  input  logic             i_mem_reg_write,
  input  logic [REG_W-1:0] i_wb_rd,
  input  logic             i_wb_reg_write,
  output fwd_sel_e         o_sel
);

  always_comb begin
    o_sel = FWD_REG;
    if (i_mem_reg_write && reg_hit(i_mem_rd, i_ex_rs))
      o_sel = FWD_MEM;
    else if (i_wb_reg_write && reg_hit(i_wb_rd, i_ex_rs))
      o_sel = FWD_WB;
  end

endmodule

// File: rtl/hazard_control_unit.sv
// Stall / flush / forwarding controller for the five-stage pipeline, with a
// data-memory wait watchdog and stall/flush performance counters.
module hazard_control_unit
  import pipeline_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  hazard_control_unit_if.slave hif
);

  localparam int                WC_W   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WC_W-1:0]   TO_MAX = WC_W'(MEM_TIMEOUT);

  hcu_state_e       r_state;
  logic [WC_W-1:0]  r_wait_cnt;
  logic             r_mem_timeout;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

  logic             w_wait, w_branch, w_load_use;
  logic             w_stall_cyc, w_flush_cyc;
  logic [WC_W-1:0]  w_cnt_nxt;

  logic [NUM_OPS-1:0][REG_W-1:0] w_ex_rs;
  fwd_sel_e                      w_fwd [NUM_OPS];

  // ---------------------------------------------------------------- decisions
  assign w_wait     = hif.mem_access && !hif.dmem_ready;
  assign w_branch   = hif.ex_branch_taken;
  assign w_load_use = hif.ex_mem_read &&
                      ((hif.id_uses_rs1 && reg_hit(hif.ex_rd, hif.id_rs1)) ||
                       (hif.id_uses_rs2 && reg_hit(hif.ex_rd, hif.id_rs2)));

  // A branch or load-use that coincides with a wait is deferred, not counted.
  assign w_stall_cyc = w_wait || (!w_branch && w_load_use);
  assign w_flush_cyc = !w_wait && w_branch;

  always_comb begin
    hif.pc_write     = 1'b1;
    hif.if_id_write  = 1'b1;
    hif.id_ex_write  = 1'b1;
    hif.ex_mem_write = 1'b1;
    hif.mem_wb_write = 1'b1;
    hif.if_id_flush  = 1'b0;
    hif.id_ex_flush  = 1'b0;
    if (reset) begin
      hif.pc_write     = 1'b0;
      hif.if_id_write  = 1'b0;
      hif.id_ex_write  = 1'b0;
      hif.ex_mem_write = 1'b0;
      hif.mem_wb_write = 1'b0;
      hif.if_id_flush  = 1'b1;
      hif.id_ex_flush  = 1'b1;
    end else if (w_wait) begin
      hif.pc_write     = 1'b0;
      hif.if_id_write  = 1'b0;
      hif.id_ex_write  = 1'b0;
      hif.ex_mem_write = 1'b0;
      hif.mem_wb_write = 1'b0;
    end else if (w_branch) begin
      hif.if_id_flush  = 1'b1;
      hif.id_ex_flush  = 1'b1;
    end else if (w_load_use) begin
      // Hold the consumer in ID and inject a bubble behind the load.
      hif.pc_write     = 1'b0;
      hif.if_id_write  = 1'b0;
      hif.id_ex_flush  = 1'b1;
    end
  end

  // --------------------------------------------------------------- forwarding
  assign w_ex_rs[0] = hif.ex_rs1;
  assign w_ex_rs[1] = hif.ex_rs2;

  for (genvar g = 0; g < NUM_OPS; g++) begin : g_fwd
    forwarding_unit u_fwd (
      .i_ex_rs         (w_ex_rs[g]),
      .i_mem_rd        (hif.mem_rd),
      .i_mem_reg_write (hif.mem_reg_write),
      .i_wb_rd         (hif.wb_rd),
      .i_wb_reg_write  (hif.wb_reg_write),
      .o_sel           (w_fwd[g])
    );
  end

  assign hif.forward_a = reset ? FWD_REG : w_fwd[0];
  assign hif.forward_b = reset ? FWD_REG : w_fwd[1];

  // --------------------------------------------------------- wait watchdog FSM
  // The counter holds the number of consecutive wait cycles seen so far, so
  // the cycle that enters MEM_WAIT already counts as the first.
  always_comb begin
    w_cnt_nxt = '0;
    unique case (r_state)
      ST_RUN:      if (w_wait) w_cnt_nxt = WC_W'(1);
      ST_MEM_WAIT: if (!hif.dmem_ready)
                     w_cnt_nxt = (r_wait_cnt == TO_MAX) ? TO_MAX
                                                        : r_wait_cnt + WC_W'(1);
      default:     w_cnt_nxt = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_RUN;
      r_wait_cnt    <= '0;
      r_mem_timeout <= 1'b0;
      r_stall_cnt   <= '0;
      r_flush_cnt   <= '0;
    end else begin
      unique case (r_state)
        ST_RUN:      if (w_wait)          r_state <= ST_MEM_WAIT;
        ST_MEM_WAIT: if (hif.dmem_ready)  r_state <= ST_RUN;
        default:                          r_state <= ST_RUN;
      endcase
      r_wait_cnt <= w_cnt_nxt;
      if (w_wait && (w_cnt_nxt == TO_MAX)) r_mem_timeout <= 1'b1;
      if (w_stall_cyc) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_flush_cyc) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign hif.mem_timeout = r_mem_timeout;
  assign hif.stall_count = r_stall_cnt;
  assign hif.flush_count = r_flush_cnt;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed-vector bench for hazard_control_unit with a queue-based scoreboard.
module tb_hazard_control_unit;
  import pipeline_pkg::*;

  localparam int CNT_W = 32;

  logic clk;
  logic rst;

  hazard_control_unit_if #(.CNT_W(CNT_W)) hif ();

  hazard_control_unit #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (rst),
    .hif   (hif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [4:0]  en;   // {pc, if_id, id_ex, ex_mem, mem_wb}
    logic [1:0]  fl;   // {if_id_flush, id_ex_flush}
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic        to;
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // Monitor: every cycle carrying an expectation is checked away from the edge.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      cmp({e.name, " en"}, 32'({hif.pc_write, hif.if_id_write, hif.id_ex_write,
                                hif.ex_mem_write, hif.mem_wb_write}), 32'(e.en));
      cmp({e.name, " flush"}, 32'({hif.if_id_flush, hif.id_ex_flush}), 32'(e.fl));
      cmp({e.name, " fwd_a"}, 32'(hif.forward_a), 32'(e.fa));
      cmp({e.name, " fwd_b"}, 32'(hif.forward_b), 32'(e.fb));
      cmp({e.name, " timeout"}, 32'(hif.mem_timeout), 32'(e.to));
      cmp({e.name, " stall_cnt"}, hif.stall_count, e.sc);
      cmp({e.name, " flush_cnt"}, hif.flush_count, e.fc);
    end
  end

  task automatic clr();
    rst                 = 1'b0;
    hif.id_rs1          = '0; hif.id_rs2      = '0;
    hif.id_uses_rs1     = 1'b0; hif.id_uses_rs2 = 1'b0;
    hif.ex_rs1          = '0; hif.ex_rs2      = '0; hif.ex_rd = '0;
    hif.ex_mem_read     = 1'b0;
    hif.ex_branch_taken = 1'b0;
    hif.mem_rd          = '0; hif.mem_reg_write = 1'b0;
    hif.mem_access      = 1'b0; hif.dmem_ready  = 1'b1;
    hif.wb_rd           = '0; hif.wb_reg_write  = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    clr();
  endtask

  task automatic expect_(input string nm, input logic [4:0] en, input logic [1:0] fl,
                         input logic [1:0] fa, input logic [1:0] fb, input logic to,
                         input logic [31:0] sc, input logic [31:0] fc);
    exp_t e;
    e.name = nm; e.en = en; e.fl = fl; e.fa = fa; e.fb = fb;
    e.to = to; e.sc = sc; e.fc = fc;
    q.push_back(e);
  endtask

  task automatic mem_wait(input logic rdy);
    hif.mem_access = 1'b1;
    hif.dmem_ready = rdy;
  endtask

  initial begin
    clr();
    rst = 1'b1;
    repeat (2) @(posedge clk);

    // Reset forces outputs even with a live forwarding match.
    cyc(); rst = 1'b1;
    hif.mem_rd = 5'd3; hif.mem_reg_write = 1'b1; hif.ex_rs1 = 5'd3;
    expect_("reset", 5'b00000, 2'b11, 2'b00, 2'b00, 1'b0, 0, 0);

    cyc();
    expect_("idle", 5'b11111, 2'b00, 2'b00, 2'b00, 1'b0, 0, 0);

    cyc();
    hif.mem_rd = 5'd7; hif.wb_rd = 5'd7; hif.ex_rs1 = 5'd7; hif.ex_rs2 = 5'd9;
    hif.mem_reg_write = 1'b1; hif.wb_reg_write = 1'b1;
    expect_("fwd_prio", 5'b11111, 2'b00, 2'b10, 2'b00, 1'b0, 0, 0);

    cyc();
    hif.mem_rd = 5'd0; hif.wb_rd = 5'd7; hif.ex_rs1 = 5'd0; hif.ex_rs2 = 5'd7;
    hif.mem_reg_write = 1'b1; hif.wb_reg_write = 1'b1;
    expect_("fwd_x0", 5'b11111, 2'b00, 2'b00, 2'b01, 1'b0, 0, 0);

    cyc();
    hif.mem_rd = 5'd4; hif.wb_rd = 5'd6; hif.ex_rs1 = 5'd6; hif.ex_rs2 = 5'd4;
    hif.mem_reg_write = 1'b1; hif.wb_reg_write = 1'b1;
    expect_("fwd_mix", 5'b11111, 2'b00, 2'b01, 2'b10, 1'b0, 0, 0);

    cyc();
    hif.ex_mem_read = 1'b1; hif.ex_rd = 5'd5; hif.id_rs1 = 5'd5; hif.id_uses_rs1 = 1'b1;
    expect_("load_use", 5'b00111, 2'b01, 2'b00, 2'b00, 1'b0, 0, 0);

    // Load has advanced to EX/MEM, consumer now in EX.
    cyc();
    hif.mem_rd = 5'd5; hif.mem_reg_write = 1'b1; hif.ex_rs1 = 5'd5;
    expect_("after_lu", 5'b11111, 2'b00, 2'b10, 2'b00, 1'b0, 1, 0);

    cyc();
    hif.ex_mem_read = 1'b1; hif.ex_rd = 5'd0; hif.id_rs1 = 5'd0; hif.id_uses_rs1 = 1'b1;
    expect_("lu_x0", 5'b11111, 2'b00, 2'b00, 2'b00, 1'b0, 1, 0);

    cyc();
    hif.ex_mem_read = 1'b1; hif.ex_rd = 5'd8; hif.id_rs2 = 5'd8;
    expect_("lu_unused", 5'b11111, 2'b00, 2'b00, 2'b00, 1'b0, 1, 0);

    cyc();
    hif.ex_mem_read = 1'b1; hif.ex_rd = 5'd8; hif.id_rs2 = 5'd8; hif.id_uses_rs2 = 1'b1;
    expect_("lu_rs2", 5'b00111, 2'b01, 2'b00, 2'b00, 1'b0, 1, 0);

    cyc(); hif.ex_branch_taken = 1'b1;
    expect_("branch", 5'b11111, 2'b11, 2'b00, 2'b00, 1'b0, 2, 0);

    cyc();
    expect_("post_br", 5'b11111, 2'b00, 2'b00, 2'b00, 1'b0, 2, 1);

    // Six-cycle wait with MEM_TIMEOUT=4.
    for (int i = 0; i < 6; i++) begin
      cyc(); mem_wait(1'b0);
      expect_($sformatf("wait%0d", i + 1), 5'b00000, 2'b00, 2'b00, 2'b00,
              (i >= 4), 32'(2 + i), 1);
    end
    cyc(); mem_wait(1'b1);
    expect_("release", 5'b11111, 2'b00, 2'b00, 2'b00, 1'b1, 8, 1);
    cyc();
    expect_("post_rel", 5'b11111, 2'b00, 2'b00, 2'b00, 1'b1, 8, 1);

    // Branch + load-use + wait: freeze, then branch flush wins.
    for (int i = 0; i < 2; i++) begin
      cyc(); mem_wait(1'b0);
      hif.ex_branch_taken = 1'b1;
      hif.ex_mem_read = 1'b1; hif.ex_rd = 5'd5; hif.id_rs1 = 5'd5; hif.id_uses_rs1 = 1'b1;
      expect_($sformatf("combo_wait%0d", i + 1), 5'b00000, 2'b00, 2'b00, 2'b00,
              1'b1, 32'(8 + i), 1);
    end
    cyc(); mem_wait(1'b1);
    hif.ex_branch_taken = 1'b1;
    hif.ex_mem_read = 1'b1; hif.ex_rd = 5'd5; hif.id_rs1 = 5'd5; hif.id_uses_rs1 = 1'b1;
    expect_("combo_rel", 5'b11111, 2'b11, 2'b00, 2'b00, 1'b1, 10, 1);
    cyc();
    expect_("combo_post", 5'b11111, 2'b00, 2'b00, 2'b00, 1'b1, 10, 2);

    // Reset in the middle of a wait.
    cyc(); mem_wait(1'b0);
    expect_("rw_wait1", 5'b00000, 2'b00, 2'b00, 2'b00, 1'b1, 10, 2);
    cyc(); mem_wait(1'b0);
    expect_("rw_wait2", 5'b00000, 2'b00, 2'b00, 2'b00, 1'b1, 11, 2);
    cyc(); mem_wait(1'b0); rst = 1'b1;
    expect_("rw_reset", 5'b00000, 2'b11, 2'b00, 2'b00, 1'b1, 12, 2);
    cyc();
    expect_("rw_after", 5'b11111, 2'b00, 2'b00, 2'b00, 1'b0, 0, 0);

    // Wait counter restarted from zero: three waits must not time out.
    for (int i = 0; i < 3; i++) begin
      cyc(); mem_wait(1'b0);
      expect_($sformatf("rw_w%0d", i + 1), 5'b00000, 2'b00, 2'b00, 2'b00,
              1'b0, 32'(i), 0);
    end
    cyc(); mem_wait(1'b1);
    expect_("rw_rel", 5'b11111, 2'b00, 2'b00, 2'b00, 1'b0, 3, 0);
    cyc();
    expect_("rw_end", 5'b11111, 2'b00, 2'b00, 2'b00, 1'b0, 3, 0);

    begin
      int budget;
      budget = 10;
      while (q.size() > 0 && budget > 0) begin
        @(posedge clk);
        budget--;
      end
      if (q.size() > 0) begin
        errors++;
        $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_control_unit.md
# hazard_control_unit

Central stall/flush/forwarding controller for the five-stage RISC-V pipeline. It sits beside the stage registers and drives them: it inspects stage-register fields, then produces PC/IF-ID write enables, IF-ID/ID-EX flushes and EX operand forwarding selects. It also tracks data-memory wait states with a timeout watchdog and keeps stall/flush performance counters.

## Interface
- MEM_TIMEOUT, 255: max consecutive data-memory wait cycles before `mem_timeout` sets.
- CNT_W, 32: performance counter width.

- clk  in  1  pipeline clock; all state on rising edge.
- reset  in  1  synchronous, active-high.
- id_rs1, id_rs2  in  5 each  source registers of the instruction in ID.
- id_uses_rs1, id_uses_rs2  in  1 each  ID instruction reads rs1/rs2.
- ex_rs1, ex_rs2  in  5 each  source registers held in ID/EX.
- ex_rd  in  5  destination in ID/EX.
- ex_mem_read  in  1  ID/EX instruction is a load.
- ex_branch_taken  in  1  branch/jump resolved taken in EX.
- mem_rd  in  5  destination in EX/MEM.
- mem_reg_write  in  1  EX/MEM writes the register file.
- mem_access  in  1  EX/MEM instruction is a load or store.
- dmem_ready  in  1  data memory completes the access this cycle.
- wb_rd  in  5  destination in MEM/WB.
- wb_reg_write  in  1  MEM/WB writes the register file.
- pc_write, if_id_write  out  1 each  stage load enables.
- id_ex_write, ex_mem_write, mem_wb_write  out  1 each  stage load enables.
- if_id_flush, id_ex_flush  out  1 each  load a bubble (all zeros) instead of the input.
- forward_a, forward_b  out  2 each  EX operand source: 00 regfile, 01 MEM/WB, 10 EX/MEM.
- mem_timeout  out  1  sticky watchdog error.
- stall_count, flush_count  out  CNT_W each  performance counters.

## Operation
- Decisions are combinational on the current inputs. FSM, wait counter, sticky flag and performance counters are registered.
- Priority, highest first: reset, memory wait, branch flush, load-use stall, normal.
- Memory wait: `mem_access && !dmem_ready`. All five write enables are 0 and both flushes are 0, so the whole pipeline freezes.
- Branch flush: `ex_branch_taken`, no wait. `if_id_flush=1`, `id_ex_flush=1`, all write enables 1.
- Load-use: `ex_mem_read && ex_rd!=0`, matching `id_rs1` with `id_uses_rs1` or `id_rs2` with `id_uses_rs2`.
  - `pc_write=0`, `if_id_write=0`, `id_ex_flush=1`.
  - Other enables are 1.
- Normal: all enables 1, flushes 0.
- Forwarding for `forward_a`:
  - 10 if `mem_reg_write && mem_rd!=0 && mem_rd==ex_rs1`.
  - Otherwise 01 if `wb_reg_write && wb_rd!=0 && wb_rd==ex_rs1`.
  - Otherwise 00.
  - EX/MEM wins when both match.
  - `forward_b` follows the same rule with `ex_rs2`.
- FSM states RUN and MEM_WAIT.
  - RUN -> MEM_WAIT when the wait condition holds.
  - MEM_WAIT -> RUN on `dmem_ready`; the release cycle is already unfrozen.
- Wait counter:
  - Cleared in RUN and incremented each cycle in MEM_WAIT, saturating at MEM_TIMEOUT.
  - When it reaches MEM_TIMEOUT, `mem_timeout` sets and stays set until reset.
  - The pipeline remains frozen until `dmem_ready`.
- Counters, both wrapping modulo 2^CNT_W:
  - `stall_count` increments on each cycle of memory wait or load-use stall.
  - `flush_count` increments on each branch-flush cycle.

## Timing
- Reset values, forced in any cycle `reset`=1:
  - All write enables 0.
  - `if_id_flush=1`, `id_ex_flush=1`.
  - `forward_a=forward_b=00`.
- Reset values registered at the clk edge with `reset`=1: state RUN, wait counter 0, `mem_timeout=0`, both counters 0.
- Zero-cycle latency for controls. Counters and `mem_timeout` update one edge after the triggering cycle.
- Load-use stall lasts exactly one cycle. The next cycle the load is in EX/MEM and `forward_*` selects 10.
- Branch during memory wait: the flush is deferred until the wait ends. `ex_branch_taken` must still be held, since ID/EX is frozen.
- Reset mid-wait: state returns to RUN and the counter clears. It does not wait for `dmem_ready`.

## Structure
- Shared package `pipeline_pkg`:
  - Forward-select encodings FWD_REG/FWD_WB/FWD_MEM.
  - FSM state enum.
  - Register-index width constant 5.
- One natural sub-module: `forwarding_unit`, purely combinational, instantiated once per operand.

## Test plan
- Load-use: `ex_mem_read=1`, `ex_rd=5`, `id_rs1=5`, `id_uses_rs1=1` -> one cycle `pc_write=0`, `if_id_write=0`, `id_ex_flush=1`; `stall_count` 0->1.
- Forwarding priority: `mem_rd=wb_rd=ex_rs1=7`, both writes 1 -> `forward_a=10`. With `mem_rd=0`, `wb_rd=7`, `ex_rs1=0`, both writes 1 -> `forward_a=00`.
- Branch taken, memory ready -> both flushes 1 and all enables 1 for one cycle; `flush_count=1`.
- MEM_TIMEOUT=4, `mem_access=1`, `dmem_ready` low 6 cycles -> enables 0 for 6 cycles, `mem_timeout` set after the 4th wait cycle, release on `dmem_ready`; `stall_count=6`.
- Branch plus load-use plus memory wait simultaneously -> freeze only; after `dmem_ready`, flush wins over stall.
- Reset asserted during MEM_WAIT -> next cycle state RUN, counters and `mem_timeout` 0, reset-forced outputs.
